// File: rtl/counter_display_pkg.sv
// Shared types and constants for the counter_display block: converter states,
// active-low seven-segment codes and the display geometry.
package counter_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_DIGITS = 3;
  localparam int BIN_W      = 8;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cv_state_e;

  // {dp,g,f,e,d,c,b,a}, active-low, dp held off
  localparam logic [7:0] SEG_0     = 8'b1100_0000;
  localparam logic [7:0] SEG_1     = 8'b1111_1001;
  localparam logic [7:0] SEG_2     = 8'b1010_0100;
  localparam logic [7:0] SEG_3     = 8'b1011_0000;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b1001_0010;
  localparam logic [7:0] SEG_6     = 8'b1000_0010;
  localparam logic [7:0] SEG_7     = 8'b1111_1000;
  localparam logic [7:0] SEG_8     = 8'b1000_0000;
  localparam logic [7:0] SEG_9     = 8'b1001_0000;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/counter_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, restarting whenever
// the input differs from the last converted value (or once after reset).
module bin2bcd_seq
  import counter_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] val,
  output logic [BCD_W-1:0] bcd,
  output logic             done_tick
);

  localparam logic [3:0] ITERS = 4'(BIN_W);

  cv_state_e        r_state, w_state_nxt;
  logic             r_first, w_first_nxt;
  logic [BIN_W-1:0] r_last_val, w_last_nxt;
  logic [BIN_W-1:0] r_bin, w_bin_nxt;
  logic [BCD_W-1:0] r_bcd, w_bcd_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [BCD_W-1:0] w_adj;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_first    <= 1'b1;
      r_last_val <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_first    <= w_first_nxt;
      r_last_val <= w_last_nxt;
      r_bin      <= w_bin_nxt;
      r_bcd      <= w_bcd_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Add-3 correction keeps each nibble a valid BCD digit after the shift
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_first_nxt = r_first;
    w_last_nxt  = r_last_val;
    w_bin_nxt   = r_bin;
    w_bcd_nxt   = r_bcd;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (r_first || (val != r_last_val)) begin
          w_bin_nxt   = val;
          w_last_nxt  = val;
          w_bcd_nxt   = '0;
          w_cnt_nxt   = ITERS;
          w_first_nxt = 1'b0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        {w_bcd_nxt, w_bin_nxt} = {w_adj, r_bin} << 1;
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bcd       = r_bcd;
  assign done_tick = (r_state == DONE);

endmodule

// File: rtl/counter_display.sv
// Converts an 8-bit value to decimal and drives a 4-digit active-low muxed
// seven-segment display. Define DISP_LEADING_ZERO_BLANK_EN to blank leading zeros.
module counter_display
  import counter_display_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] val,
  output logic [3:0]       an,
  output logic [7:0]       sseg,
  output logic             bcd_valid
);

  logic [BCD_W-1:0]                  w_bcd;
  logic                              w_done;
  logic [BCD_DIGITS-1:0][3:0]        r_d;
  logic [REFRESH_BITS-1:0]           r_refresh;
  logic                              r_bcd_valid;
  logic [1:0]                        w_sel;
  logic [BCD_DIGITS-1:0]             w_blank;

  bin2bcd_seq u_conv (
    .clk       (clk),
    .reset     (reset),
    .val       (val),
    .bcd       (w_bcd),
    .done_tick (w_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d         <= '0;
      r_refresh   <= '0;
      r_bcd_valid <= 1'b0;
    end else begin
      r_refresh   <= r_refresh + 1'b1;
      r_bcd_valid <= w_done;
      if (w_done) r_d <= w_bcd;
    end
  end

  assign bcd_valid = r_bcd_valid;
  assign w_sel     = r_refresh[REFRESH_BITS-1 -: 2];

`ifdef DISP_LEADING_ZERO_BLANK_EN
  assign w_blank[2] = (r_d[2] == 4'd0);
  assign w_blank[1] = (r_d[2] == 4'd0) && (r_d[1] == 4'd0);
  assign w_blank[0] = 1'b0;
`else
  assign w_blank = '0;
`endif

  // Blanked digits keep their anode on; only the segments go dark
  always_comb begin
    an   = 4'b1111;
    sseg = SEG_BLANK;
    case (w_sel)
      2'd0: begin
        an   = 4'b1110;
        sseg = w_blank[0] ? SEG_BLANK : seg_decode(r_d[0]);
      end
      2'd1: begin
        an   = 4'b1101;
        sseg = w_blank[1] ? SEG_BLANK : seg_decode(r_d[1]);
      end
      2'd2: begin
        an   = 4'b1011;
        sseg = w_blank[2] ? SEG_BLANK : seg_decode(r_d[2]);
      end
      default: begin
        an   = 4'b0111;
        sseg = SEG_BLANK;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_display.sv
// Directed bench for counter_display with a 4-bit refresh counter so every
// digit is shown within 16 clocks.
module tb_counter_display;

`ifdef DISP_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] val;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       bcd_valid;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] dig [4];

  counter_display #(.REFRESH_BITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .val       (val),
    .an        (an),
    .sseg      (sseg),
    .bcd_valid (bcd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Collect the segment pattern shown under each anode over one full refresh period
  task automatic read_digits(input string tag);
    int bad_an;
    bad_an = 0;
    for (int i = 0; i < 4; i++) dig[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: dig[0] = sseg;
        4'b1101: dig[1] = sseg;
        4'b1011: dig[2] = sseg;
        4'b0111: dig[3] = sseg;
        default: bad_an++;
      endcase
    end
    chk({tag, " an_onehot"}, 32'(bad_an), 32'd0);
  endtask

  task automatic check_digits(input string tag, input logic [7:0] e2, input logic [7:0] e1,
                              input logic [7:0] e0);
    read_digits(tag);
    chk({tag, " d0"}, 32'(dig[0]), 32'(e0));
    chk({tag, " d1"}, 32'(dig[1]), 32'(e1));
    chk({tag, " d2"}, 32'(dig[2]), 32'(e2));
    chk({tag, " d3"}, 32'(dig[3]), 32'h0000_00FF);
  endtask

  // Negedges from now until bcd_valid is seen; -1 if it never comes
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bcd_valid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, first, pulses, p1, p2;
    logic [7:0] e;
    reset = 1'b1;
    val   = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst an", 32'(an), 32'b1110);
    chk("rst sseg", 32'(sseg), 32'hC0);
    chk("rst valid", 32'(bcd_valid), 32'd0);

    // first conversion after release, and anode rotation at known refresh counts
    reset  = 1'b0;
    first  = 0;
    pulses = 0;
    for (int m = 1; m <= 14; m++) begin
      @(negedge clk);
      if (bcd_valid) begin
        pulses++;
        if (first == 0) first = m;
      end
      if (m == 2)  chk("rot an0", 32'(an), 32'b1110);
      if (m == 6)  chk("rot an1", 32'(an), 32'b1101);
      if (m == 10) chk("rot an2", 32'(an), 32'b1011);
      if (m == 14) chk("rot an3", 32'(an), 32'b0111);
    end
    chk("first lat", 32'(first), 32'd10);
    chk("first pulses", 32'(pulses), 32'd1);
    check_digits("v0", LZB ? 8'hFF : 8'hC0, LZB ? 8'hFF : 8'hC0, 8'hC0);

    val = 8'd255;
    wait_valid(n);
    chk("v255 lat", 32'(n), 32'd10);
    @(negedge clk);
    chk("v255 pulse drop", 32'(bcd_valid), 32'd0);
    check_digits("v255", 8'hA4, 8'h92, 8'h92);

    val = 8'd100;
    wait_valid(n);
    chk("v100 lat", 32'(n), 32'd10);
    check_digits("v100", 8'hF9, 8'hC0, 8'hC0);

    // 10 -> 200 while the 10 conversion is in flight
    val = 8'd10;
    repeat (3) @(negedge clk);
    val    = 8'd200;
    pulses = 0;
    p1     = 0;
    p2     = 0;
    for (int m = 4; m <= 24; m++) begin
      @(negedge clk);
      if (bcd_valid) begin
        pulses++;
        if (pulses == 1) p1 = m;
        if (pulses == 2) p2 = m;
      end
      if (pulses == 1) begin
        case (an)
          4'b1110: e = 8'hC0;
          4'b1101: e = 8'hF9;
          4'b1011: e = LZB ? 8'hFF : 8'hC0;
          4'b0111: e = 8'hFF;
          default: e = 8'h00;
        endcase
        chk("v10 seg", 32'(sseg), 32'(e));
      end
    end
    chk("b2b p1", 32'(p1), 32'd10);
    chk("b2b p2", 32'(p2), 32'd20);
    check_digits("v200", 8'hA4, 8'hC0, 8'hC0);

    val = 8'd7;
    wait_valid(n);
    chk("v7 lat", 32'(n), 32'd10);
    check_digits("v7", LZB ? 8'hFF : 8'hC0, LZB ? 8'hFF : 8'hC0, 8'hF8);

    // reset during the fourth shift iteration
    val = 8'd42;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst an", 32'(an), 32'b1110);
    chk("midrst sseg", 32'(sseg), 32'hC0);
    chk("midrst valid", 32'(bcd_valid), 32'd0);
    pulses = 0;
    for (int m = 0; m < 12; m++) begin
      @(negedge clk);
      if (bcd_valid) pulses++;
    end
    chk("midrst pulses", 32'(pulses), 32'd0);
    chk("midrst an hold", 32'(an), 32'b1110);
    reset = 1'b0;
    wait_valid(n);
    chk("v42 lat", 32'(n), 32'd10);
    check_digits("v42", LZB ? 8'hFF : 8'hC0, 8'h99, 8'hA4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
